// File: rtl/fetch_predict_stage.sv
// Instruction-fetch stage: PC register, instruction-memory address and next-PC
// prediction from an 8-entry bimodal BHT plus an 8-entry direct-mapped BTB.
module fetch_predict_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [1:0]  BHT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [15:0] imem_data,
    input  logic [15:0] IF_ID_PC_curr,
    input  logic [15:0] IF_ID_PC_next,
    input  logic        wen_BHT,
    input  logic        wen_BTB,
    input  logic        actual_taken,
    input  logic [15:0] branch_target,
    input  logic        update_PC,
    output logic [15:0] imem_addr,
    output logic [15:0] PC_curr,
    output logic [15:0] PC_next,
    output logic [15:0] PC_inst,
    output logic        predicted_taken,
    output logic [15:0] predicted_target
);

    logic [15:0]       pc_q, pc_d;
    logic [7:0][1:0]   bht_q, bht_d;
    logic [7:0]        btb_valid_q, btb_valid_d;
    logic [7:0][11:0]  btb_tag_q, btb_tag_d;
    logic [7:0][15:0]  btb_target_q, btb_target_d;

    logic [2:0] lu_idx, up_idx;
    logic       btb_hit, hlt;
    logic       unused_pc_bit;

    assign lu_idx        = pc_q[3:1];
    assign up_idx        = IF_ID_PC_curr[3:1];
    assign unused_pc_bit = IF_ID_PC_curr[0];

    // Lookup reads only the registered tables, so a same-index write is seen next cycle.
    always_comb begin
        PC_curr          = pc_q;
        imem_addr        = pc_q;
        PC_next          = pc_q + 16'd2;
        PC_inst          = imem_data;
        hlt              = (imem_data[15:12] == 4'hF);
        btb_hit          = btb_valid_q[lu_idx] && (btb_tag_q[lu_idx] == pc_q[15:4]);
        predicted_taken  = btb_hit && bht_q[lu_idx][1];
        predicted_target = predicted_taken ? btb_target_q[lu_idx] : PC_next;
    end

    always_comb begin
        pc_d         = pc_q;
        bht_d        = bht_q;
        btb_valid_d  = btb_valid_q;
        btb_tag_d    = btb_tag_q;
        btb_target_d = btb_target_q;

        if (rst) begin
            pc_d        = RESET_PC;
            btb_valid_d = '0;
            for (int unsigned i = 0; i < 8; i++) begin
                bht_d[i] = BHT_INIT;
            end
        end else begin
            if (update_PC) begin
                pc_d = actual_taken ? branch_target : IF_ID_PC_next;
            end else if (!stall && !hlt) begin
                pc_d = predicted_target;
            end

            if (wen_BHT) begin
                if (actual_taken) begin
                    if (bht_q[up_idx] != 2'b11) bht_d[up_idx] = bht_q[up_idx] + 2'd1;
                end else begin
                    if (bht_q[up_idx] != 2'b00) bht_d[up_idx] = bht_q[up_idx] - 2'd1;
                end
            end

            if (wen_BTB) begin
                btb_valid_d[up_idx]  = 1'b1;
                btb_tag_d[up_idx]    = IF_ID_PC_curr[15:4];
                btb_target_d[up_idx] = branch_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        pc_q         <= pc_d;
        bht_q        <= bht_d;
        btb_valid_q  <= btb_valid_d;
        btb_tag_q    <= btb_tag_d;
        btb_target_q <= btb_target_d;
    end

endmodule

// File: tb/tb_fetch_predict_stage.sv
// Directed bench for fetch_predict_stage: reset, sequencing, stall, BHT/BTB
// training and saturation, redirects, aliasing, HLT, wrap-around, mid-run reset.
module tb_fetch_predict_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [15:0] imem_data;
    logic [15:0] IF_ID_PC_curr;
    logic [15:0] IF_ID_PC_next;
    logic        wen_BHT;
    logic        wen_BTB;
    logic        actual_taken;
    logic [15:0] branch_target;
    logic        update_PC;
    logic [15:0] imem_addr;
    logic [15:0] PC_curr;
    logic [15:0] PC_next;
    logic [15:0] PC_inst;
    logic        predicted_taken;
    logic [15:0] predicted_target;

    int checks = 0;
    int errors = 0;

    fetch_predict_stage #(.RESET_PC(16'h0000), .BHT_INIT(2'b01)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .imem_data        (imem_data),
        .IF_ID_PC_curr    (IF_ID_PC_curr),
        .IF_ID_PC_next    (IF_ID_PC_next),
        .wen_BHT          (wen_BHT),
        .wen_BTB          (wen_BTB),
        .actual_taken     (actual_taken),
        .branch_target    (branch_target),
        .update_PC        (update_PC),
        .imem_addr        (imem_addr),
        .PC_curr          (PC_curr),
        .PC_next          (PC_next),
        .PC_inst          (PC_inst),
        .predicted_taken  (predicted_taken),
        .predicted_target (predicted_target)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        stall = 0; wen_BHT = 0; wen_BTB = 0; actual_taken = 0; update_PC = 0;
    endtask

    task automatic redirect(input logic [15:0] tgt);
        update_PC = 1; actual_taken = 1; branch_target = tgt;
        step();
        update_PC = 0; actual_taken = 0;
    endtask

    initial begin
        rst = 1; idle();
        imem_data = 16'h8123; IF_ID_PC_curr = 16'h0000; IF_ID_PC_next = 16'h0000;
        branch_target = 16'h0000;
        step(); step();
        chk("rst_pc", PC_curr, 16'h0000);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_next", PC_next, 16'h0002);
        chk("rst_ptaken", {15'd0, predicted_taken}, 16'h0000);
        chk("rst_ptarget", predicted_target, 16'h0002);
        rst = 0;
        step(); chk("seq_pc2", PC_curr, 16'h0002);
        step(); chk("seq_pc4", PC_curr, 16'h0004);
        chk("inst_pass", PC_inst, 16'h8123);

        // stall at 0x0010
        redirect(16'h0010);
        chk("redir_10", PC_curr, 16'h0010);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", PC_curr, 16'h0010);
            chk("stall_inst", PC_inst, 16'h8123);
        end
        stall = 0;
        step(); chk("stall_rel", PC_curr, 16'h0012);

        // train 0x0020 -> 0x0040 (counter 01 -> 10)
        IF_ID_PC_curr = 16'h0020; branch_target = 16'h0040;
        wen_BTB = 1; wen_BHT = 1; actual_taken = 1;
        step(); idle();
        chk("train_seq", PC_curr, 16'h0014);
        redirect(16'h0020);
        chk("pt_taken", {15'd0, predicted_taken}, 16'h0001);
        chk("pt_target", predicted_target, 16'h0040);
        step(); chk("pt_follow", PC_curr, 16'h0040);
        chk("tagmiss_40", {15'd0, predicted_taken}, 16'h0000);

        // four not-taken: 10 -> 01 -> 00 -> 00 -> 00
        wen_BHT = 1; actual_taken = 0; IF_ID_PC_curr = 16'h0020;
        for (int i = 0; i < 4; i++) step();
        idle();
        chk("nt_seq", PC_curr, 16'h0048);
        // one taken (00 -> 01) with redirect to 0x0020: still not predicted
        wen_BHT = 1; redirect(16'h0020); wen_BHT = 0;
        chk("sat_lo_pc", PC_curr, 16'h0020);
        chk("sat_lo_pt", {15'd0, predicted_taken}, 16'h0000);
        chk("sat_lo_tgt", predicted_target, 16'h0022);
        // 01 -> 10
        wen_BHT = 1; redirect(16'h0020); wen_BHT = 0;
        chk("inc_pt", {15'd0, predicted_taken}, 16'h0001);
        // 10 -> 11 -> 11
        wen_BHT = 1; redirect(16'h0020); redirect(16'h0020); wen_BHT = 0;
        // not-taken 11 -> 10; lookup must see pre-edge value in the write cycle
        wen_BHT = 1; actual_taken = 0; update_PC = 1; IF_ID_PC_next = 16'h0020;
        #1 chk("pre_edge_pt", {15'd0, predicted_taken}, 16'h0001);
        step(); idle();
        chk("sat_hi_pc", PC_curr, 16'h0020);
        chk("sat_hi_pt", {15'd0, predicted_taken}, 16'h0001);

        // mispredict overrides stall
        update_PC = 1; actual_taken = 0; IF_ID_PC_next = 16'h0022; stall = 1;
        step(); chk("misp_nt", PC_curr, 16'h0022);
        actual_taken = 1; branch_target = 16'h0100;
        step(); chk("misp_t", PC_curr, 16'h0100);
        idle();

        // aliasing: 0x0120 shares index 0 with 0x0020
        redirect(16'h0120);
        chk("alias_pt", {15'd0, predicted_taken}, 16'h0000);
        step(); chk("alias_next", PC_curr, 16'h0122);

        // HLT holds PC until a redirect
        redirect(16'h0030);
        imem_data = 16'hF000;
        for (int i = 0; i < 3; i++) step();
        chk("hlt_hold", PC_curr, 16'h0030);
        redirect(16'h0050);
        chk("hlt_redir", PC_curr, 16'h0050);
        imem_data = 16'h8123;

        // wrap-around
        redirect(16'hFFFE);
        chk("wrap_next", PC_next, 16'h0000);
        step(); chk("wrap_pc", PC_curr, 16'h0000);

        // reset mid-run discards redirect and updates
        redirect(16'h0060);
        rst = 1; update_PC = 1; actual_taken = 1; branch_target = 16'h0200;
        wen_BHT = 1; IF_ID_PC_curr = 16'h0020;
        step(); idle(); rst = 0;
        chk("midrst_pc", PC_curr, 16'h0000);
        // BTB valid cleared: counter 01 -> 10 but no BTB entry, so no prediction
        wen_BHT = 1; redirect(16'h0020); wen_BHT = 0;
        chk("midrst_btb", {15'd0, predicted_taken}, 16'h0000);
        chk("midrst_tgt", predicted_target, 16'h0022);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_predict_stage.md
# fetch_predict_stage

Instruction-fetch stage of the pipelined 16-bit CPU. Holds the PC, drives the instruction-memory address, and predicts the next PC with an 8-entry 2-bit bimodal BHT plus an 8-entry direct-mapped BTB. It consumes the decode stage's resolved branch information (`wen_BHT`, `wen_BTB`, `actual_taken`, `branch_target`, `update_PC`) and produces the fetched word, `PC_next` and the prediction that travel through IF/ID into decode.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `BHT_INIT`, default 2'b01: reset value of every BHT counter (weakly not taken).
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: reset. One clock; reset is synchronous and active-high.
- `stall` input 1: hazard-unit PC stall; hold the PC.
- `imem_data` input 16: instruction word at `imem_addr`, combinational read.
- `IF_ID_PC_curr` input 16: address of the instruction now in decode; indexes BHT/BTB updates.
- `IF_ID_PC_next` input 16: fall-through address (PC+2) of the instruction in decode.
- `wen_BHT` input 1: update the BHT counter for `IF_ID_PC_curr`.
- `wen_BTB` input 1: write a BTB entry for `IF_ID_PC_curr`.
- `actual_taken` input 1: resolved branch direction.
- `branch_target` input 16: resolved branch target.
- `update_PC` input 1: mispredict; redirect fetch.
- `imem_addr` output 16: equals `PC_curr`.
- `PC_curr` output 16: current PC.
- `PC_next` output 16: `PC_curr` + 2, modulo 2^16.
- `PC_inst` output 16: equals `imem_data`.
- `predicted_taken` output 1: prediction for the current fetch.
- `predicted_target` output 16: predicted next PC.

## Operation
- Index = PC[3:1], tag = PC[15:4]. PC[0] is ignored for both lookup and update.
- BTB entry contents: valid, 12-bit tag, 16-bit target.
- BTB hit: the entry is valid and its tag equals `PC_curr[15:4]`.
- `predicted_taken` = BTB hit AND BHT[index][1].
- `predicted_target` = BTB target when `predicted_taken`, else `PC_next`.
- HLT detect: `imem_data[15:12]` == 4'hF.
- Next-PC priority, highest first:
  1. `update_PC`: load `branch_target` if `actual_taken`, else `IF_ID_PC_next`. This overrides `stall` and HLT.
  2. `stall`: hold the PC.
  3. HLT fetched: hold the PC.
  4. Otherwise: load `predicted_target`.
- BHT update when `wen_BHT`: counter at `IF_ID_PC_curr[3:1]` saturates at both ends.
  - +1 if `actual_taken`, saturating at 11.
  - −1 otherwise, saturating at 00.
- BTB update when `wen_BTB`: entry at `IF_ID_PC_curr[3:1]` ← {1, `IF_ID_PC_curr[15:4]`, `branch_target`}. This overwrites any prior entry (no associativity).
- `stall` does not block BHT or BTB updates.
- Lookup and update are independent ports. When they hit the same index in the same cycle, the lookup sees the pre-edge value.

## Timing
- Lookup, `PC_next`, `imem_addr` and `PC_inst` are combinational from the PC register. The prediction is therefore available in the same cycle as the fetch.
- Redirects, PC loads, and BHT/BTB writes take effect at the next rising edge. Mispredict penalty from this block is 1 cycle: the wrong-path fetch is in IF while `update_PC` is high.
- While `rst` is high at an edge, the following load, and all other updates are ignored:
  - PC ← `RESET_PC`.
  - All BHT counters ← `BHT_INIT`.
  - All BTB valid bits ← 0.
- Values after reset:
  - `PC_curr` = `imem_addr` = 0x0000.
  - `PC_next` = 0x0002.
  - `predicted_taken` = 0.
  - `predicted_target` = 0x0002.
- Reset mid-operation discards any pending redirect or update in that cycle.
- Wrap-around: PC 0xFFFE with no branch → next PC 0x0000.
- Decode asserts `wen_BHT`, `wen_BTB` and `update_PC` in the same cycle as the instruction they resolve. There is no handshake.

## Test plan
- Reset → `PC_curr` 0x0000, `predicted_taken` 0. Release with non-branch words (0x8123) and no stall → PC 0x0000, 0x0002, 0x0004 on successive edges.
- `stall` high for 3 cycles at PC 0x0010 → PC holds at 0x0010 and `PC_inst` is stable; on release, next PC is 0x0012.
- Train PC 0x0020 with target 0x0040:
  - First edge: `wen_BTB` and `wen_BHT` with taken. Counter 01→10.
  - Next fetch of 0x0020: `predicted_taken` 1, `predicted_target` 0x0040, next PC 0x0040.
  - Four not-taken updates: counter goes 10→01→00 and stays at 00; `predicted_taken` 0.
- Mispredict: `update_PC` 1, `actual_taken` 0, `IF_ID_PC_next` 0x0022, with `stall` also 1 → next PC 0x0022. Repeat with `actual_taken` 1 and `branch_target` 0x0100 → next PC 0x0100.
- Aliasing: BTB entry trained for 0x0020. Fetch 0x0120 (same index, different tag) → `predicted_taken` 0, next PC 0x0122.
- HLT: `imem_data` 0xF000 at PC 0x0030 → PC holds at 0x0030 indefinitely. `update_PC` with `branch_target` 0x0050 and `actual_taken` 1 → next PC 0x0050. PC 0xFFFE with a non-branch word → next PC 0x0000.
